word_framer: RTL and testbench

WORD_FRAMER -- requirements
Module: word_framer

---
 rtl/word_framer.sv | 117 +++++++++++
 tb/tb_word_framer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_framer.sv
// Splits a raw ASCII byte stream into uppercase words separated by a single 0,
// dropping any word longer than MAX_LEN letters in its entirety.
module word_framer #(
  parameter int MAX_LEN = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] words,
  output logic [7:0] word_count,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {FILL, DRAIN, TERM, DISCARD} state_t;

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] rd_q, rd_d;
  logic [7:0] words_q, words_d;
  logic [7:0] word_count_q, word_count_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic [7:0] buf_q [MAX_LEN];

  logic       buf_wr;
  logic       is_upper, is_lower, is_letter;
  logic [7:0] upper_char;
  logic       accept;

  assign in_ready   = (state_q == FILL) || (state_q == DISCARD);
  assign accept     = in_valid && in_ready;
  assign words      = words_q;
  assign word_count = word_count_q;
  assign drop_count = drop_count_q;

  always_comb begin
    is_upper   = (in_data >= 8'h41) && (in_data <= 8'h5A);
    is_lower   = (in_data >= 8'h61) && (in_data <= 8'h7A);
    is_letter  = is_upper || is_lower;
    upper_char = is_lower ? (in_data - 8'h20) : in_data;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    len_d        = len_q;
    rd_d         = rd_q;
    words_d      = 8'd0;
    word_count_d = word_count_q;
    drop_count_d = drop_count_q;
    buf_wr       = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (is_letter) begin
            if (len_q < MAX_LEN_B) begin
              buf_wr = 1'b1;
              len_d  = len_q + 8'd1;
            end else begin
              // One letter too many: the whole word is abandoned, never partially emitted.
              len_d   = 8'd0;
              state_d = DISCARD;
              if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
            end
          end else if (len_q != 8'd0) begin
            rd_d    = 8'd0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        words_d = buf_q[rd_q[IDX_W-1:0]];
        rd_d    = rd_q + 8'd1;
        if (rd_q == len_q - 8'd1) state_d = TERM;
      end
      TERM: begin
        len_d        = 8'd0;
        word_count_d = word_count_q + 8'd1;
        state_d      = FILL;
      end
      DISCARD: begin
        if (accept && !is_letter) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= FILL;
      len_q        <= 8'd0;
      rd_q         <= 8'd0;
      words_q      <= 8'd0;
      word_count_q <= 8'd0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_q         <= rd_d;
      words_q      <= words_d;
      word_count_q <= word_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // NOTE: the word buffer has no reset; len_q gates every read, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (buf_wr) buf_q[len_q[IDX_W-1:0]] <= upper_char;
  end

endmodule

// File: tb/tb_word_framer.sv
// Directed self-checking bench for word_framer: exact drain timing, delimiter
// collapsing, overlong-word dropping, stalls, mid-drain reset and counter limits.
module tb_word_framer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] words;
  logic [7:0] word_count;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic       prev_nz = 1'b0;

  word_framer #(.MAX_LEN(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .words      (words),
    .word_count (word_count),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  // Records every non-zero output byte plus the single 0 that follows each run.
  always @(negedge clock) begin
    if (reset) begin
      prev_nz = 1'b0;
    end else begin
      if (words !== 8'd0 || prev_nz) got.push_back(words);
      prev_nz = (words !== 8'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed=in_ready_low expected=in_ready_high");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_words", words, 8'd0);
    check("rst_word_count", word_count, 8'd0);
    check("rst_drop_count", drop_count, 8'd0);
    check("rst_in_ready", in_ready, 1'b1);

    // "qu " fed back-to-back: cycle-exact drain timing.
    in_valid = 1'b1; in_data = 8'h71; step();
    check("qu_ready_q", in_ready, 1'b1);
    in_data = 8'h75; step();
    in_data = 8'h20; step();
    check("qu_ready_k", in_ready, 1'b0);
    check("qu_words_k", words, 8'd0);
    in_valid = 1'b0; in_data = 8'h61;
    step();
    check("qu_words_k1", words, 8'd81);
    check("qu_ready_k1", in_ready, 1'b0);
    step();
    check("qu_words_k2", words, 8'd85);
    check("qu_ready_k2", in_ready, 1'b0);
    step();
    check("qu_words_k3", words, 8'd0);
    check("qu_ready_k3", in_ready, 1'b1);
    check("qu_word_count", word_count, 8'd1);

    // Repeated delimiters collapse.
    idle(2);
    got.delete();
    send_str("A,,  B.");
    idle(6);
    exp_q = '{8'd65, 8'd0, 8'd66, 8'd0};
    check_stream("collapse");
    check("collapse_word_count", word_count, 8'd3);

    // Letter-class boundaries, with 8'h00 as a delimiter.
    got.delete();
    send_byte(8'h41); send_byte(8'h40); send_byte(8'h5A); send_byte(8'h5B);
    send_byte(8'h61); send_byte(8'h60); send_byte(8'h7A); send_byte(8'h7B);
    send_byte(8'h42); send_byte(8'h00);
    idle(5);
    exp_q = '{8'd65, 8'd0, 8'd90, 8'd0, 8'd65, 8'd0, 8'd90, 8'd0, 8'd66, 8'd0};
    check_stream("class");
    check("class_word_count", word_count, 8'd8);

    // Exactly MAX_LEN letters is emitted in full.
    got.delete();
    for (int i = 0; i < 15; i++) send_byte(8'h78);
    send_byte(8'h20);
    idle(20);
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(8'd88);
    exp_q.push_back(8'd0);
    check_stream("max15");
    check("max15_word_count", word_count, 8'd9);

    // MAX_LEN+1 letters is dropped without any output.
    got.delete();
    for (int i = 0; i < 16; i++) send_byte(8'h78);
    send_byte(8'h20);
    idle(20);
    check("drop16_got", got.size(), 0);
    check("drop16_drop_count", drop_count, 8'd1);
    check("drop16_word_count", word_count, 8'd9);
    send_str("ab ");
    idle(6);
    exp_q = '{8'd65, 8'd66, 8'd0};
    check_stream("after_drop");

    // in_valid toggling with junk on in_data while invalid.
    got.delete();
    for (int i = 0; i < 3; i++) begin
      send_byte((i == 0) ? 8'h68 : (i == 1) ? 8'h69 : 8'h20);
      in_data = 8'h7A;
      step();
    end
    idle(6);
    exp_q = '{8'd72, 8'd73, 8'd0};
    check_stream("toggle");
    check("toggle_word_count", word_count, 8'd11);

    // An unterminated word stays buffered until a delimiter arrives.
    got.delete();
    send_str("zz");
    idle(10);
    check("hold_got", got.size(), 0);
    check("hold_ready", in_ready, 1'b1);
    send_byte(8'h20);
    idle(6);
    exp_q = '{8'd90, 8'd90, 8'd0};
    check_stream("hold_release");

    // Reset one cycle into DRAIN abandons the word.
    got.delete();
    send_str("abc ");
    step();
    check("mid_drain_words", words, 8'd65);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_words", words, 8'd0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_word_count", word_count, 8'd0);
    idle(8);
    check("mid_rst_got", got.size(), 0);
    check("mid_rst_words_late", words, 8'd0);

    // word_count wrap and drop_count saturation.
    do_reset();
    for (int i = 0; i < 255; i++) send_str("a ");
    idle(5);
    check("wc_255", word_count, 8'd255);
    send_str("a ");
    idle(5);
    check("wc_wrap", word_count, 8'd0);
    got.delete();
    for (int w = 0; w < 300; w++) begin
      for (int i = 0; i < 16; i++) send_byte(8'h6B);
      send_byte(8'h2E);
      if (w == 254) check("dc_255", drop_count, 8'd255);
    end
    idle(5);
    check("dc_sat", drop_count, 8'd255);
    check("dc_word_count", word_count, 8'd0);
    check("dc_got", got.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
